// File: rtl/prog_loader.sv
// Program loader: streams instructions into instruction memory while holding the CPU in reset.
// Optional macro PROG_LOADER_CLEAR_EN zero-fills the whole memory before each load.
module prog_loader #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int RELEASE_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  prog_enable,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0] HOLD_LAST = 4'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
`ifdef PROG_LOADER_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [3:0]            hold_q;
  logic                  done_q;

  logic [ADDR_WIDTH:0]   len_d;
  logic                  beat;
  logic                  last_beat;

  assign len_d     = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign beat      = (state_q == S_LOAD) && in_valid;
  assign last_beat = beat && ({1'b0, ptr_q} == (len_q - 1'b1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            len_q  <= len_d;
            ptr_q  <= '0;
            hold_q <= '0;
`ifdef PROG_LOADER_CLEAR_EN
            state_q <= S_CLEAR;
`else
            state_q <= (len_d == '0) ? S_HOLD : S_LOAD;
`endif
          end
        end
`ifdef PROG_LOADER_CLEAR_EN
        S_CLEAR: begin
          // Pointer wraps back to 0 after the last cleared address, ready for LOAD.
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) state_q <= (len_q == '0) ? S_HOLD : S_LOAD;
        end
`endif
        S_LOAD: begin
          if (last_beat) state_q <= S_HOLD;
          else if (beat) ptr_q <= ptr_q + 1'b1;
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= S_RUN;
            done_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign cpu_reset   = (state_q != S_RUN);
  assign prog_enable = (state_q != S_RUN);
  assign done        = done_q;
  assign mem_addr    = ptr_q;

`ifdef PROG_LOADER_CLEAR_EN
  assign busy      = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_HOLD);
  assign mem_we    = beat || (state_q == S_CLEAR);
  assign mem_wdata = (state_q == S_CLEAR) ? '0 : in_data;
`else
  assign busy      = (state_q == S_LOAD) || (state_q == S_HOLD);
  assign mem_we    = beat;
  assign mem_wdata = in_data;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a per-load model of expected addresses/data and control phases.
module tb_prog_loader;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int RD    = 3;
  localparam int DEPTH = 16;
`ifdef PROG_LOADER_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, mem_we, prog_enable, cpu_reset, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .prog_enable(prog_enable),
    .cpu_reset(cpu_reset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory as seen by the CPU cluster, filled only by the DUT write port.
  logic [DW-1:0] cap [DEPTH];
  int            wr_count = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      cap[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  logic [DW-1:0] model [DEPTH];
  bit            mvalid [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_ctrl(input string ph, input logic rdy, input logic we,
                             input logic bsy, input logic dn, input logic crst);
    chk({ph, ".in_ready"},    32'(in_ready),    32'(rdy));
    chk({ph, ".mem_we"},      32'(mem_we),      32'(we));
    chk({ph, ".busy"},        32'(busy),        32'(bsy));
    chk({ph, ".done"},        32'(done),        32'(dn));
    chk({ph, ".cpu_reset"},   32'(cpu_reset),   32'(crst));
    chk({ph, ".prog_enable"}, 32'(prog_enable), 32'(crst));
  endtask

  task automatic run_load(input int len, input int valid_pct, input logic [7:0] pat,
                          input int pat_len, input int abort_after, input bit poke);
    int eff = (len > DEPTH) ? DEPTH : len;
    int ptr = 0;
    int cyc = 0;
    int w0;
    logic v;
    logic [DW-1:0] d;
    $display("load len=%0d eff=%0d pct=%0d pat_len=%0d abort=%0d poke=%0d",
             len, eff, valid_pct, pat_len, abort_after, poke);
    @(negedge clk);
    w0 = wr_count;
    load_start = 1'b1;
    load_len   = len[AW:0];
    in_valid   = 1'b0;
    if (CLR != 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'($urandom_range(0, 1));
        #1;
        expect_ctrl("clear", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clear.addr",  32'(mem_addr),  32'(i));
        chk("clear.wdata", 32'(mem_wdata), 32'h0);
        model[i]  = '0;
        mvalid[i] = 1'b1;
      end
    end
    while (ptr < eff && !(abort_after >= 0 && ptr == abort_after) && cyc < 500) begin
      @(negedge clk);
      load_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      load_len   = (AW+1)'($urandom_range(0, 20));
      v = (pat_len > 0) ? pat[cyc % pat_len] : 1'($urandom_range(0, 99) < valid_pct);
      d = DW'($urandom);
      in_valid = v;
      in_data  = d;
      #1;
      expect_ctrl("load", 1'b1, v, 1'b1, 1'b0, 1'b1);
      if (v) begin
        chk("load.addr",  32'(mem_addr),  32'(ptr));
        chk("load.wdata", 32'(mem_wdata), 32'(d));
        model[ptr]  = d;
        mvalid[ptr] = 1'b1;
        ptr++;
      end
      cyc++;
    end
    if (abort_after >= 0) begin
      @(negedge clk);
      in_valid   = 1'b0;
      load_start = 1'b0;
      reset_n    = 1'b0;
      @(negedge clk);
      #1;
      expect_ctrl("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset_n = 1'b1;
      chk("abort.writes", 32'(wr_count - w0), 32'(abort_after + CLR * DEPTH));
      return;
    end
    for (int i = 0; i < RD; i++) begin
      @(negedge clk);
      load_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid   = 1'($urandom_range(0, 1));
      #1;
      expect_ctrl("hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'($urandom_range(0, 1));
    #1;
    expect_ctrl("run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    expect_ctrl("run2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("writes", 32'(wr_count - w0), 32'(eff + CLR * DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (mvalid[i]) chk($sformatf("mem[%0d]", i), 32'(cap[i]), 32'(model[i]));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    expect_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    expect_ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    run_load(10, 100, 8'h00, 0, -1, 1'b0);
    run_load(4,    0, 8'h2D, 6, -1, 1'b0);
    run_load(0,  100, 8'h00, 0, -1, 1'b0);
    run_load(20,  80, 8'h00, 0, -1, 1'b0);
    run_load(16,  90, 8'h00, 0, -1, 1'b0);
    run_load(7,   60, 8'h00, 0, -1, 1'b1);
    run_load(8,  100, 8'h00, 0,  3, 1'b0);
    run_load(5,   70, 8'h00, 0, -1, 1'b0);
    for (int k = 0; k < 4; k++)
      run_load($urandom_range(0, 20), $urandom_range(30, 100), 8'h00, 0, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Sequencer that loads a program into the 4-bit CPU's instruction memory over a valid/ready byte stream. While loading, it holds the CPU in reset and steers the instruction-memory address mux to the programming port. When the load finishes, it returns the mux to the CPU and releases CPU reset. It is the synthesizable replacement for hand-driven program/flash sequencing and sits between an external loader source (UART/host) and the `mux_2to1` + `memory` + `cpu_4bit` cluster.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: instruction memory address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: instruction width (one `instruction_t`).
- `RELEASE_DELAY`, 1: cycles spent in HOLD before CPU reset is released; legal range 1..15.

Ports:
- `clk`  in  1  single clock for all logic. The memory write port is also clocked by `clk`.
- `reset_n`  in  1  reset, synchronous and active-low.
- `load_start`  in  1  one-cycle request to begin a load.
- `load_len`  in  ADDR_WIDTH+1  number of instructions to load; sampled with `load_start`.
- `in_valid`  in  1  stream data valid.
- `in_data`  in  DATA_WIDTH  instruction byte.
- `in_ready`  out  1  loader accepts a beat.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_WIDTH  programming address; drives the mux programming input.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `prog_enable`  out  1  mux select; 1 selects `mem_addr`, 0 selects the CPU fetch address.
- `cpu_reset`  out  1  active-high reset to `cpu_4bit`.
- `busy`  out  1  high in CLEAR, LOAD or HOLD.
- `done`  out  1  one-cycle pulse on entry to RUN.

## Operation
- States: IDLE, CLEAR (only when the macro is defined), LOAD, HOLD, RUN.
- Reset values: state=IDLE, write pointer=0, `cpu_reset`=1, `prog_enable`=1, `in_ready`=0, `mem_we`=0, `busy`=0, `done`=0.
- IDLE:
  - The CPU is held in reset and the mux selects programming.
  - On `load_start`, go to CLEAR (if the macro is defined) or LOAD.
- Length capture:
  - Capture `load_len`, clamped to 2^ADDR_WIDTH.
  - Reset the pointer to 0.
- LOAD:
  - `in_ready`=1.
  - A beat transfers when `in_valid && in_ready`.
  - On a transfer, `mem_we` = `in_valid & in_ready` (combinational), `mem_addr` = pointer, `mem_wdata` = `in_data`, and the pointer increments.
  - When the beat at pointer = len-1 transfers, go to HOLD.
  - The pointer never wraps.
- `load_len`=0: skip LOAD entirely (CLEAR, if enabled, still runs); go to HOLD with no data writes.
- HOLD:
  - `in_ready`=0, `cpu_reset`=1, `prog_enable`=1.
  - After RELEASE_DELAY cycles, go to RUN.
- RUN:
  - `cpu_reset`=0 and `prog_enable`=0.
  - `done`=1 in the first RUN cycle only.
  - On `load_start`, go back to CLEAR/LOAD. `cpu_reset` and `prog_enable` return to 1 in the next cycle.
- `load_start` is ignored in CLEAR, LOAD and HOLD.
- `cpu_reset`, `prog_enable`, `busy`, `done` and `in_ready` are decoded from registered state only. `mem_we` and `mem_wdata` are the only input-dependent outputs.

## Timing
- `load_start` is sampled at edge N. The target state (CLEAR or LOAD) is active from N+1; in LOAD, `in_ready` is high from that cycle.
- One beat per cycle is sustained. Write latency is 0: the memory captures the beat at the same edge that completes the handshake.
- The last beat at edge E causes HOLD during [E, E+RELEASE_DELAY). RUN begins at edge E+RELEASE_DELAY, where `cpu_reset` falls and `done` pulses.
- `reset_n`=0 at any edge, including mid-load, forces the reset values at that edge. Partial memory contents are left as written, and the next load restarts at address 0.

## Configuration
- Macro: `PROG_LOADER_CLEAR_EN`.
- Defined: the CLEAR state writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle (`mem_we`=1, `in_ready`=0), then goes to LOAD. This adds 2^ADDR_WIDTH cycles, and unloaded locations decode as instruction 0.
- Undefined: there is no CLEAR state; IDLE/RUN go directly to LOAD, and unloaded locations keep their prior contents.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles -> `cpu_reset`=1, `prog_enable`=1, `in_ready`=`mem_we`=`busy`=`done`=0.
- Load 10 instructions (the R3 fill/BNE loop program), `in_valid` high every cycle, RELEASE_DELAY=1:
  - addresses 0..9 written in order;
  - `in_ready` falls after the 10th beat;
  - `done`=1 and `cpu_reset`=0 one cycle later;
  - the CPU then fills data memory 0..15 with 15..0.
- Gapped `in_valid` (1,0,1,1,0,1) with len=4 -> exactly 4 writes at addresses 0..3; the pointer does not advance on idle cycles.
- Length edges:
  - len=0 -> no `mem_we`, RUN after HOLD;
  - len=20 -> clamped, writes to addresses 0..15, then HOLD after address 15 with no wrap.
- Reload and abort:
  - `load_start` in RUN -> `cpu_reset`=1 and `prog_enable`=1 the next cycle, load restarts at address 0;
  - `load_start` during LOAD is ignored;
  - `reset_n`=0 after 3 beats -> IDLE, and the following load writes from address 0.
- With `PROG_LOADER_CLEAR_EN`, len=2 -> 16 zero writes to addresses 0..15 with `in_ready`=0, then 2 data writes to addresses 0..1, then HOLD.
